// File: rtl/mii_rx_framer.sv
`timescale 1ns/1ps
// mii_rx_framer
//   MII receive framer. Registers the PHY nibble stream, strips preamble/SFD,
//   pairs nibbles (LS first) into bytes and emits a valid-only byte stream with
//   sof/eof markers, frame length and error status. The last byte of a frame is
//   held back in a pending register until the end of the frame is known, so
//   rx_eof always accompanies real data.
//
//   Optional feature macro: FCS_CHECK_EN -- enables the byte-wise CRC-32 check
//   (reflected 0xEDB88320, init all ones, residue 0xDEBB20E3). When undefined
//   rx_fcs_bad is constant 0 and FCS bytes pass through unchecked.
//
// Ports
//   clk_in      25 MHz MII receive clock
//   rst         synchronous, active-high reset
//   mii_rxd     PHY receive nibble
//   mii_rx_dv   PHY data valid
//   mii_rx_er   PHY receive error
//   rx_data     received byte, qualified by rx_valid
//   rx_valid    one-cycle byte strobe, no backpressure
//   rx_sof      first byte after SFD
//   rx_eof      last byte of the frame
//   rx_err      frame bad (with rx_eof)
//   rx_len      frame byte count incl. FCS (with rx_eof)
//   rx_fcs_bad  FCS mismatch (with rx_eof)
//   frame_cnt   good frames, wrapping
//   drop_cnt    errored/discarded frames, wrapping
module mii_rx_framer #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int LEN_W           = 11
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [3:0]       mii_rxd,
  input  logic             mii_rx_dv,
  input  logic             mii_rx_er,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_err,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_fcs_bad,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA_LO, DATA_HI, DROP} state_t;

  state_t           state;
  logic [3:0]       rxd_q;
  logic             dv_q, er_q;
  logic             idle_seen;
  logic [3:0]       lo_nib;
  logic [7:0]       pend_data;
  logic             pend_vld, pend_sof;
  logic [LEN_W-1:0] byte_cnt;
  logic             er_sticky;
  logic [7:0]       new_byte;
  logic             fcs_bad_now;
  logic             flush, flush_err, runt;

  assign new_byte = {rxd_q, lo_nib};
  assign runt     = byte_cnt < LEN_W'(MIN_FRAME_BYTES);

`ifdef FCS_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign fcs_bad_now = (crc != 32'hDEBB20E3);
`else
  assign fcs_bad_now = 1'b0;
`endif

  // End-of-frame decision. An odd-nibble end or the (MAX+1)th byte forces the
  // error bit; the other sources are already accumulated.
  always_comb begin
    flush     = 1'b0;
    flush_err = er_sticky | runt | fcs_bad_now;
    case (state)
      DATA_LO: flush = !dv_q && pend_vld;
      DATA_HI: begin
        if (!dv_q) begin
          flush     = pend_vld;
          flush_err = 1'b1;
        end else if (byte_cnt == LEN_W'(MAX_FRAME_BYTES)) begin
          flush     = 1'b1;
          flush_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      rxd_q      <= '0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      idle_seen  <= 1'b0;
      lo_nib     <= '0;
      pend_data  <= '0;
      pend_vld   <= 1'b0;
      pend_sof   <= 1'b0;
      byte_cnt   <= '0;
      er_sticky  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_err     <= 1'b0;
      rx_len     <= '0;
      rx_fcs_bad <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
`ifdef FCS_CHECK_EN
      crc        <= '1;
`endif
    end else begin
      rxd_q      <= mii_rxd;
      dv_q       <= mii_rx_dv;
      er_q       <= mii_rx_er;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_err     <= 1'b0;
      rx_fcs_bad <= 1'b0;

      if ((state == DATA_LO || state == DATA_HI) && dv_q && er_q) er_sticky <= 1'b1;

      // Output stage: either flush the pending byte as eof, or release it as a
      // normal byte when its successor completes.
      if (flush) begin
        rx_valid   <= 1'b1;
        rx_data    <= pend_data;
        rx_sof     <= pend_sof;
        rx_eof     <= 1'b1;
        rx_err     <= flush_err;
        rx_len     <= byte_cnt;
        rx_fcs_bad <= fcs_bad_now;
        pend_vld   <= 1'b0;
        if (flush_err) drop_cnt  <= drop_cnt + 16'd1;
        else           frame_cnt <= frame_cnt + 16'd1;
      end else if (state == DATA_HI && dv_q && pend_vld) begin
        rx_valid <= 1'b1;
        rx_data  <= pend_data;
        rx_sof   <= pend_sof;
      end

      case (state)
        IDLE: begin
          if (!dv_q)                          idle_seen <= 1'b1;
          else if (idle_seen && rxd_q == 4'h5) state    <= PREAMBLE;
          else                                 state    <= DROP;
        end
        PREAMBLE: begin
          if (!dv_q) state <= IDLE;
          else if (rxd_q == 4'hD) begin
            state     <= DATA_LO;
            byte_cnt  <= '0;
            er_sticky <= 1'b0;
            pend_vld  <= 1'b0;
`ifdef FCS_CHECK_EN
            crc       <= '1;
`endif
          end else if (rxd_q != 4'h5) state <= DROP;
        end
        DATA_LO: begin
          if (!dv_q) begin
            state <= IDLE;
            if (!pend_vld) drop_cnt <= drop_cnt + 16'd1;
          end else begin
            lo_nib <= rxd_q;
            state  <= DATA_HI;
          end
        end
        DATA_HI: begin
          if (!dv_q) begin
            state <= IDLE;
            if (!pend_vld) drop_cnt <= drop_cnt + 16'd1;
          end else if (byte_cnt == LEN_W'(MAX_FRAME_BYTES)) begin
            // Byte MAX+1 completed: the frame was truncated by the flush above.
            state <= DROP;
          end else begin
            pend_data <= new_byte;
            pend_vld  <= 1'b1;
            pend_sof  <= (byte_cnt == '0);
            byte_cnt  <= byte_cnt + LEN_W'(1);
`ifdef FCS_CHECK_EN
            crc       <= crc_byte(crc, new_byte);
`endif
            state     <= DATA_LO;
          end
        end
        DROP: if (!dv_q) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
`timescale 1ns/1ps
module tb_mii_rx_framer;
  localparam int MAXB = 1522, MINB = 64, LW = 11, T = 40;

  logic          clk_in = 1'b0, rst = 1'b1;
  logic [3:0]    mii_rxd = '0;
  logic          mii_rx_dv = 1'b0, mii_rx_er = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_sof, rx_eof, rx_err, rx_fcs_bad;
  logic [LW-1:0] rx_len;
  logic [15:0]   frame_cnt, drop_cnt;

  mii_rx_framer #(.MAX_FRAME_BYTES(MAXB), .MIN_FRAME_BYTES(MINB), .LEN_W(LW)) dut (
    .clk_in(clk_in), .rst(rst), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv),
    .mii_rx_er(mii_rx_er), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .rx_err(rx_err), .rx_len(rx_len), .rx_fcs_bad(rx_fcs_bad),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));

  always #(T/2) clk_in = ~clk_in;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] d; logic sof, eof, err, fcs; int len; time t; } exp_t;

  int   total = 0, bad = 0;
  exp_t q[$];
  bit   quiet = 1'b0;
  int   quiet_valid = 0, quiet_eof = 0;
  int   m_frames = 0, m_drops = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // FCS is good when the trailing four bytes equal ~CRC of the rest, LS byte first.
  function automatic bit fcs_bad_of(input bq_t b, input int len);
    logic [31:0] c, f;
    c = '1;
    if (len < 4) return 1'b1;
    for (int i = 0; i < len - 4; i++) c = crc_upd(c, b[i]);
    f = {b[len-1], b[len-2], b[len-3], b[len-4]};
    return f != ~c;
  endfunction

  task automatic mk_frame(input int n, input bit good, output bq_t b);
    logic [31:0] c;
    logic [7:0]  x;
    b = {};
    c = '1;
    if (n < 4) begin
      for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
      return;
    end
    for (int i = 0; i < n - 4; i++) begin
      x = 8'($urandom_range(0, 255));
      b.push_back(x);
      c = crc_upd(c, x);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
    if (!good) begin
      x = b[n-1] ^ 8'h01;
      b[n-1] = x;
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk_in) begin
    exp_t e;
    if (rx_valid) begin
      if (quiet) begin
        quiet_valid++;
        if (rx_eof) quiet_eof++;
      end else begin
        if (!rx_eof) chk("gap_before_byte", prev_valid, 1'b0);
        if (q.size() == 0) chk("unexpected_pulse", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("data", rx_data, e.d);
          chk("sof", rx_sof, e.sof);
          chk("eof", rx_eof, e.eof);
          chk("latency", $time, e.t);
          if (e.eof) begin
            chk("err", rx_err, e.err);
            chk("len", rx_len, e.len);
            chk("fcs_bad", rx_fcs_bad, e.fcs);
          end
        end
      end
    end
    prev_valid <= rx_valid;
  end

  task automatic nib(input logic [3:0] d, input logic dv, input logic er);
    @(negedge clk_in);
    mii_rxd = d; mii_rx_dv = dv; mii_rx_er = er;
    @(posedge clk_in);
  endtask

  task automatic preamble();
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'(m_frames));
    chk({tag, "_drop_cnt"}, drop_cnt, 16'(m_drops));
    chk({tag, "_leftover"}, q.size(), 0);
  endtask

  // Sends a frame (preamble, SFD, bytes, optional stray low nibble) and queues
  // what the framer should produce.
  task automatic send_frame(input string tag, input bq_t b, input int er_idx, input bit odd);
    int   n, len, k;
    bit   err, fb;
    exp_t e;
    logic [7:0] x;
    logic er;
    n   = b.size();
    len = (n > MAXB) ? MAXB : n;
    fb  = fcs_bad_of(b, len);
`ifndef FCS_CHECK_EN
    fb  = 1'b0;
`endif
    err = (er_idx >= 0 && er_idx < n) || (len < MINB) || odd || (n > MAXB) || fb;
    preamble();
    for (int i = 0; i < n; i++) begin
      x  = b[i];
      er = (i == er_idx);
      nib(x[3:0], 1'b1, er);
      nib(x[7:4], 1'b1, er);
      if (i < len) begin
        k = (i == len - 1 && n <= MAXB && !odd) ? 2 : 3;
        e.d = x; e.sof = (i == 0); e.eof = (i == len - 1);
        e.err = err; e.fcs = fb; e.len = len; e.t = $time + k*T + T/2;
        q.push_back(e);
      end
    end
    if (odd) nib(4'hA, 1'b1, 1'b0);
    idle(12);
    if (n == 0 || err) m_drops++;
    else               m_frames++;
    chk_cnts(tag);
  endtask

  initial begin
    bq_t b, b64;
    logic [7:0] x;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", rx_valid, 0); chk("rst_sof", rx_sof, 0); chk("rst_eof", rx_eof, 0);
    chk("rst_err", rx_err, 0); chk("rst_len", rx_len, 0); chk("rst_data", rx_data, 0);
    chk("rst_fcs", rx_fcs_bad, 0); chk("rst_fcnt", frame_cnt, 0); chk("rst_dcnt", drop_cnt, 0);
    @(negedge clk_in) rst = 1'b0;
    idle(4);

    // Good 64-byte frame, then the same frame with rx_er on byte 10
    mk_frame(64, 1'b1, b64);
    send_frame("good64", b64, -1, 1'b0);
    send_frame("rxer", b64, 10, 1'b0);

    // Odd-nibble end after 64 bytes, and a 20-byte runt
    send_frame("align", b64, -1, 1'b1);
    mk_frame(20, 1'b1, b);
    send_frame("runt", b, -1, 1'b0);

    // SFD followed immediately by dv=0, and by a lone nibble
    b = {};
    send_frame("empty", b, -1, 1'b0);
    send_frame("one_nib", b, -1, 1'b1);

    // Single byte frame: sof and eof on the same byte
    mk_frame(1, 1'b1, b);
    send_frame("one_byte", b, -1, 1'b0);

    // Broken preamble: discarded silently
    nib(4'h5, 1'b1, 1'b0); nib(4'h5, 1'b1, 1'b0); nib(4'h3, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) nib(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    idle(12);
    chk_cnts("bad_pre");

    // Oversize frame, then a clean frame
    mk_frame(1600, 1'b1, b);
    send_frame("oversize", b, -1, 1'b0);
    mk_frame(MAXB, 1'b1, b);
    send_frame("max_len", b, -1, 1'b0);
    send_frame("after_over", b64, -1, 1'b0);

    // Corrupted FCS byte
    b = b64;
    x = b[63] ^ 8'h01;
    b[63] = x;
    send_frame("fcs_corrupt", b, -1, 1'b0);

    // Randomized frames
    for (int r = 0; r < 10; r++) begin
      int n, er_idx;
      bit odd;
      n      = $urandom_range(1, 100);
      er_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      odd    = ($urandom_range(0, 4) == 0);
      mk_frame(n, $urandom_range(0, 3) != 0, b);
      send_frame("rand", b, er_idx, odd);
    end

    // Reset in the middle of a frame
    quiet = 1'b1; quiet_valid = 0; quiet_eof = 0;
    preamble();
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom_range(0, 255));
      if (i == 15) rst = 1'b1;
      nib(x[3:0], 1'b1, 1'b0);
      if (i == 15) begin
        #1;
        chk("midrst_valid", rx_valid, 0); chk("midrst_eof", rx_eof, 0);
        chk("midrst_err", rx_err, 0); chk("midrst_len", rx_len, 0);
        chk("midrst_fcnt", frame_cnt, 0); chk("midrst_dcnt", drop_cnt, 0);
      end
      nib(x[7:4], 1'b1, 1'b0);
      if (i == 15) begin
        rst = 1'b0;
        quiet_valid = 0;
      end
    end
    idle(12);
    quiet = 1'b0;
    m_frames = 0; m_drops = 0;
    chk("midrst_no_valid", quiet_valid, 0);
    chk("midrst_no_eof", quiet_eof, 0);
    chk_cnts("midrst");
    send_frame("after_rst", b64, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
